// File: rtl/dff_obs_checker.sv
// dff_obs_checker
//   Stimulus driver / response reader for a bank of DFF primitive instances.
//   An 8-bit Galois LFSR produces d/en/sr once per step; after a settle
//   window the synchronised observation bus is compared with the expected
//   vector from an external model, mismatching steps are counted
//   (saturating) and a pass flag is reported at the end of the run.
//
//   Optional feature macro: DFF_CHK_FIRST_FAIL_EN
//     adds first_step / first_bit, which capture the step and the lowest
//     differing bit of the first mismatching sample of a run.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               pulse, starts a run when idle
//   obs[W]              DFF bank outputs (asynchronous, synchronised here)
//   exp[W]              expected obs for step_idx, sampled while exp_req
//   exp_req             high in the sample cycle
//   step_idx[16]        current step
//   stim_d/en/sr        stimulus to the DFF bank
//   busy                high from accepted start until the done cycle
//   done                one-cycle end-of-run pulse
//   pass                1 iff the run had no mismatches (valid from done)
//   err_cnt[16]         mismatching steps, saturating at 16'hFFFF
//   first_step[16], first_bit[clog2(W)]   only with DFF_CHK_FIRST_FAIL_EN
module dff_obs_checker #(
    parameter int          W            = 88,
    parameter int          NUM_STEPS    = 64,
    parameter int          SETTLE       = 4,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5,
    // Value err_cnt is loaded with at start; 0 for normal operation, a value
    // near 16'hFFFF lets the saturation path be reached in a short run.
    parameter logic [15:0] ERR_CNT_INIT = 16'h0000,
    localparam int         FB_W         = (W > 1) ? $clog2(W) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [W-1:0]    obs,
    input  logic [W-1:0]    exp,
    output logic            exp_req,
    output logic [15:0]     step_idx,
    output logic            stim_d,
    output logic            stim_en,
    output logic            stim_sr,
    output logic            busy,
    output logic            done,
    output logic            pass,
`ifdef DFF_CHK_FIRST_FAIL_EN
    output logic [15:0]     first_step,
    output logic [FB_W-1:0] first_bit,
`endif
    output logic [15:0]     err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE, S_CHECK, S_DONE
    } state_t;

    // x^8+x^6+x^5+x^4+1, right-shifting Galois form
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    state_t         state_q, state_d;
    logic [7:0]     lfsr_q, lfsr_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [15:0]    step_q, step_d;
    logic [15:0]    err_q, err_d;
    logic           pass_q, pass_d;
    logic [2:0]     stim_q, stim_d3;
    logic [W-1:0]   obs_s1_q, obs_s1_d;
    logic [W-1:0]   obs_s_q, obs_s_d;
    logic           mismatch;

`ifdef DFF_CHK_FIRST_FAIL_EN
    logic [15:0]    fstep_q, fstep_d;
    logic [FB_W-1:0] fbit_q, fbit_d;
    logic           fseen_q, fseen_d;
    logic [W-1:0]   diff;
    logic [FB_W-1:0] low_bit;

    // Descending scan so the lowest set bit is the one that sticks.
    always_comb begin
        diff    = obs_s_q ^ exp;
        low_bit = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (diff[i]) low_bit = FB_W'(i);
        end
    end
`endif

    assign mismatch = (obs_s_q != exp);

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        err_d    = err_q;
        pass_d   = pass_q;
        stim_d3  = stim_q;
        obs_s1_d = obs;
        obs_s_d  = obs_s1_q;
`ifdef DFF_CHK_FIRST_FAIL_EN
        fstep_d  = fstep_q;
        fbit_d   = fbit_q;
        fseen_d  = fseen_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    step_d  = '0;
                    err_d   = ERR_CNT_INIT;
                    pass_d  = 1'b0;
                    lfsr_d  = LFSR_SEED;
`ifdef DFF_CHK_FIRST_FAIL_EN
                    fstep_d = '0;
                    fbit_d  = '0;
                    fseen_d = 1'b0;
`endif
                end
            end
            S_DRIVE: begin
                // {sr, en, d} = lfsr[2:0] of the state before advancing
                stim_d3 = lfsr_q[2:0];
                lfsr_d  = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
                cnt_d   = 8'(SETTLE - 1);
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == 8'd0) state_d = S_SAMPLE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
`ifdef DFF_CHK_FIRST_FAIL_EN
                    if (!fseen_q) begin
                        fseen_d = 1'b1;
                        fstep_d = step_q;
                        fbit_d  = low_bit;
                    end
`endif
                end
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (step_q == 16'(NUM_STEPS - 1)) begin
                    state_d = S_DONE;
                    pass_d  = (err_q == 16'd0);
                end else begin
                    step_d  = step_q + 16'd1;
                    state_d = S_DRIVE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            lfsr_q   <= LFSR_SEED;
            cnt_q    <= '0;
            step_q   <= '0;
            err_q    <= '0;
            pass_q   <= 1'b0;
            stim_q   <= '0;
            obs_s1_q <= '0;
            obs_s_q  <= '0;
`ifdef DFF_CHK_FIRST_FAIL_EN
            fstep_q  <= '0;
            fbit_q   <= '0;
            fseen_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            err_q    <= err_d;
            pass_q   <= pass_d;
            stim_q   <= stim_d3;
            obs_s1_q <= obs_s1_d;
            obs_s_q  <= obs_s_d;
`ifdef DFF_CHK_FIRST_FAIL_EN
            fstep_q  <= fstep_d;
            fbit_q   <= fbit_d;
            fseen_q  <= fseen_d;
`endif
        end
    end

    assign exp_req  = (state_q == S_SAMPLE);
    assign done     = (state_q == S_DONE);
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign step_idx = step_q;
    assign err_cnt  = err_q;
    assign pass     = pass_q;
    assign stim_d   = stim_q[0];
    assign stim_en  = stim_q[1];
    assign stim_sr  = stim_q[2];
`ifdef DFF_CHK_FIRST_FAIL_EN
    assign first_step = fstep_q;
    assign first_bit  = fbit_q;
`endif

endmodule

// File: tb/tb_dff_obs_checker.sv
module tb_dff_obs_checker;

    localparam int W      = 88;
    localparam int NSTEP  = 4;
    localparam int SET    = 2;
    localparam int RUNLEN = NSTEP * (SET + 3) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  obs = '0;
    logic [W-1:0]  exp1;
    logic          exp_req, stim_d, stim_en, stim_sr, busy, done, pass;
    logic [15:0]   step_idx, err_cnt;

    logic          start2 = 1'b0;
    logic [W-1:0]  exp2;
    logic          exp_req2, stim_d2, stim_en2, stim_sr2, busy2, done2, pass2;
    logic [15:0]   step_idx2, err_cnt2;

`ifdef DFF_CHK_FIRST_FAIL_EN
    logic [15:0]   first_step, first_step2;
    logic [6:0]    first_bit, first_bit2;
`endif

    logic [W-1:0]  mask_tbl [16];
    int            n_chk = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    // External model: exp = obs with a per-step corruption mask applied
    always_comb exp1 = obs ^ mask_tbl[step_idx[3:0]];
    assign exp2 = ~obs;

    dff_obs_checker #(.W(W), .NUM_STEPS(NSTEP), .SETTLE(SET), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .obs(obs), .exp(exp1),
        .exp_req(exp_req), .step_idx(step_idx), .stim_d(stim_d), .stim_en(stim_en),
        .stim_sr(stim_sr), .busy(busy), .done(done), .pass(pass),
`ifdef DFF_CHK_FIRST_FAIL_EN
        .first_step(first_step), .first_bit(first_bit),
`endif
        .err_cnt(err_cnt)
    );

    dff_obs_checker #(.W(W), .NUM_STEPS(5), .SETTLE(1), .ERR_CNT_INIT(16'hFFFD)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .obs(obs), .exp(exp2),
        .exp_req(exp_req2), .step_idx(step_idx2), .stim_d(stim_d2), .stim_en(stim_en2),
        .stim_sr(stim_sr2), .busy(busy2), .done(done2), .pass(pass2),
`ifdef DFF_CHK_FIRST_FAIL_EN
        .first_step(first_step2), .first_bit(first_bit2),
`endif
        .err_cnt(err_cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Next LFSR state: shift right, fold polynomial x^8+x^6+x^5+x^4+1 on a 1 out
    function automatic logic [7:0] lfsr_nx(input logic [7:0] s);
        logic [7:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 8'b1011_1000;
        return n;
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err"}, err_cnt, 0);
        chk({tag, "_step"}, step_idx, 0);
        chk({tag, "_expreq"}, exp_req, 0);
        chk({tag, "_stim"}, {stim_sr, stim_en, stim_d}, 0);
    endtask

    // mode 0: all match, 1: single bit 17 flipped on step 2, 2: random masks
    task automatic run(input int mode, input bit mid_start);
        logic [95:0] r;
        logic [7:0]  st;
        logic [2:0]  last_stim;
        int k, cyc, dones, want_err, want_fs, want_fb;
        bit seen;

        for (int i = 0; i < 16; i++) mask_tbl[i] = '0;
        if (mode == 1) mask_tbl[2] = 88'd1 << 17;
        if (mode == 2) begin
            for (int i = 0; i < NSTEP; i++) begin
                r = {$urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom}
                  & {$urandom, $urandom, $urandom};
                if ($urandom_range(0, 1) == 1) mask_tbl[i] = r[W-1:0];
            end
        end
        r   = {$urandom, $urandom, $urandom};
        obs = r[W-1:0];
        repeat (3) @(negedge clk);

        want_err = 0; want_fs = 0; want_fb = 0; seen = 0;
        for (int i = 0; i < NSTEP; i++) begin
            if (mask_tbl[i] != '0) begin
                want_err++;
                if (!seen) begin
                    seen = 1;
                    want_fs = i;
                    for (int b = W - 1; b >= 0; b--) if (mask_tbl[i][b]) want_fb = b;
                end
            end
        end

        start = 1'b1;
        k = 0; cyc = 0; dones = 0; st = 8'hA5; last_stim = '0;
        while (cyc < 4 * RUNLEN && dones == 0) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (mid_start && cyc == 6) start = 1'b1;
            if (mid_start && cyc == 7) start = 1'b0;
            if (done) begin
                dones++;
                chk("busy_at_done", busy, 0);
            end else begin
                chk("busy_run", busy, 1);
            end
            if (exp_req) begin
                chk("step_idx", step_idx, k);
                chk("stim", {stim_sr, stim_en, stim_d}, st[2:0]);
                last_stim = st[2:0];
                st = lfsr_nx(st);
                k++;
            end
        end
        chk("latency", cyc, RUNLEN);
        chk("samples", k, NSTEP);
        chk("err_cnt", err_cnt, want_err);
        chk("pass", pass, (want_err == 0));
`ifdef DFF_CHK_FIRST_FAIL_EN
        chk("first_step", first_step, want_fs);
        chk("first_bit", first_bit, want_fb);
`endif
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("done_cnt", dones, 1);
        chk("busy_after", busy, 0);
        chk("stim_hold", {stim_sr, stim_en, stim_d}, last_stim);
        chk("pass_hold", pass, (want_err == 0));
    endtask

    initial begin
        int cyc;
        int dones;

        for (int i = 0; i < 16; i++) mask_tbl[i] = '0;
        #1;
        check_idle_zero("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("post_rst");

        run(0, 0);
        run(1, 0);
        run(2, 0);
        run(2, 1);
        run(2, 0);
        run(0, 1);

        // Reset during SETTLE of step 3
        start = 1'b1;
        cyc = 0;
        @(negedge clk);
        start = 1'b0;
        while (step_idx != 16'd3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_step3", (cyc < 100), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_zero("abort");
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);
        run(1, 0);

        // Saturating error counter on the preloaded instance
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("sat_done", done2, 1);
        chk("sat_err", err_cnt2, 16'hFFFF);
        chk("sat_pass", pass2, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dff_obs_checker.md
Name: dff_obs_checker

Overview:
Stimulus-driver and response-reader for the flip-flop primitive verification targets.
- Drives the shared d/en/sr nets consumed by a bank of DFF instances.
- Samples the bank's wide observation bus after a settle window.
- Compares each sample against an expected vector supplied per step by an external model or ROM.
- Accumulates mismatch statistics and reports pass/fail.

Parameters:
W, 88, width of observation bus and expected vector
NUM_STEPS, 64, number of stimulus steps per run (1..65535)
SETTLE, 4, cycles between stimulus update and sample (1..255)
LFSR_SEED, 8'hA5, nonzero seed of 8-bit stimulus LFSR

Ports:
clk  in  1  single system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a run when idle
obs  in  W  DFF bank outputs (asynchronous to clk; synchronised internally)
exp  in  W  expected obs for current step, valid while exp_req high
exp_req  out  1  high in SAMPLE; external model must present exp for step_idx
step_idx  out  16  current step number
stim_d  out  1  drive to DUT d
stim_en  out  1  drive to DUT en
stim_sr  out  1  drive to DUT sr
busy  out  1  high from accepted start until DONE
done  out  1  one-cycle pulse at end of run
pass  out  1  valid from done pulse until next start; 1 iff zero mismatches
err_cnt  out  16  count of mismatching steps, saturating at 16'hFFFF

Behaviour:
- Reset: all outputs 0; FSM IDLE; LFSR = LFSR_SEED; sync flops cleared.
- obs passes through a 2-flop synchroniser (obs_s); only obs_s is compared.
- FSM states:
  - IDLE: waits for start.
  - start=1 -> DRIVE: step_idx=0, err_cnt=0, pass=0, busy=1, LFSR reloaded with seed.
  - DRIVE (1 cycle): stim_{d,en,sr} <= LFSR[0],LFSR[1],LFSR[2]; LFSR advances, taps x^8+x^6+x^5+x^4+1 (Galois); settle counter loaded with SETTLE-1.
  - SETTLE: counts down; at 0 -> SAMPLE. Stimulus held stable.
  - SAMPLE (1 cycle): exp_req=1; compare obs_s vs exp on this edge; any differing bit increments err_cnt (saturating) -> CHECK.
  - CHECK: if step_idx==NUM_STEPS-1 -> DONE, else step_idx+1 -> DRIVE.
  - DONE (1 cycle): done=1, busy=0, pass=(err_cnt==0) -> IDLE.
- start while busy is ignored.
- Stimulus outputs hold last value after the run until next DRIVE.
- Per-step latency = 1 + SETTLE + 2 cycles. Total run = NUM_STEPS*(SETTLE+3)+1 cycles from start to done.
- rst_n low mid-run: immediate abort to reset values. No done pulse is produced.
- err_cnt saturation: stays 16'hFFFF; pass=0.

Optional Feature:
Macro DFF_CHK_FIRST_FAIL_EN.
- Defined: adds outputs first_step (16) and first_bit (7).
  - Captured on the first mismatching SAMPLE of a run.
  - first_bit = lowest differing bit index.
  - Held until next start; both read 0 if no failure.
  - Port width of first_bit is clog2(W), which is 7 for W=88.
- Undefined: ports absent; no capture logic.

Test Plan:
1. NUM_STEPS=4, SETTLE=2, exp tied to obs (loopback, obs stable) -> done after 4*5+1=21 cycles from start; pass=1; err_cnt=0.
2. exp=obs^(1<<17) on step 2 only -> err_cnt=1; pass=0. With DFF_CHK_FIRST_FAIL_EN: first_step=2, first_bit=17.
3. Default seed 8'hA5, DRIVE sequence -> stim_{d,en,sr} of first three steps match LFSR states A5 and its next two successors computed by the bench model.
4. exp always mismatched, NUM_STEPS=65535 with forced err_cnt preload near max -> err_cnt saturates at 16'hFFFF; no wrap.
5. rst_n asserted during SETTLE of step 3 -> all outputs 0 within the same cycle; no done. A following start runs a clean full sequence from step 0.
6. start pulsed during busy -> ignored; step_idx sequence unchanged; exactly one done pulse.
